// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared definitions for player/NPC movers:
//   - direction indices into the 4-bit button/enable vectors
//   - edge-handling mode selectors
//   - mover FSM state type and encodings
//   - helper that turns a one-hot button vector into a direction index
// -----------------------------------------------------------------------------
package player_pkg;

  // Bit positions in btns / move_en: [3]=U, [2]=D, [1]=R, [0]=L
  localparam int DIR_U = 3;
  localparam int DIR_D = 2;
  localparam int DIR_R = 1;
  localparam int DIR_L = 0;

  // Edge handling for down/left/right moves
  localparam int EDGE_WRAP  = 0;
  localparam int EDGE_CLAMP = 1;

  // Mover FSM state
  typedef logic [0:0] moverState_t;
  localparam moverState_t IDLE = 1'b0;
  localparam moverState_t HOLD = 1'b1;

  // Direction index of a one-hot button vector; callers qualify with $onehot
  function automatic logic [1:0] dirIndex(input logic [3:0] b);
    case (b)
      4'b1000: dirIndex = 2'(DIR_U);
      4'b0100: dirIndex = 2'(DIR_D);
      4'b0010: dirIndex = 2'(DIR_R);
      default: dirIndex = 2'(DIR_L);
    endcase
  endfunction

endpackage

// File: rtl/player_step_calc.sv
// -----------------------------------------------------------------------------
// player_step_calc
// Combinational next-position calculator for one move of a rectangular object.
// Ports:
//   dir    in  2        direction index (player_pkg::DIR_*)
//   xCur   in  COORD_W  current column (top-left)
//   yCur   in  COORD_W  current row (top-left)
//   objW   in  COORD_W  object width
//   objH   in  COORD_W  object height
//   xNext  out COORD_W  column after the move
//   yNext  out COORD_W  row after the move
//   passUp out 1        the up-move went off the top edge (level pass)
// -----------------------------------------------------------------------------
module player_step_calc #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int COORD_W   = 11,
  parameter int STEP      = 12,
  parameter int EDGE_MODE = 0
) (
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] xCur,
  input  logic [COORD_W-1:0] yCur,
  input  logic [COORD_W-1:0] objW,
  input  logic [COORD_W-1:0] objH,
  output logic [COORD_W-1:0] xNext,
  output logic [COORD_W-1:0] yNext,
  output logic               passUp
);
  import player_pkg::*;

  // One extra bit so pos + size + STEP cannot overflow before the compare
  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] SCR_W = EW'(SCREEN_W);
  localparam logic [EW-1:0] SCR_H = EW'(SCREEN_H);
  localparam logic [EW-1:0] STP   = EW'(STEP);

  logic [EW-1:0] xE, yE, wE, hE, xMax, yMax;

  assign xE   = {1'b0, xCur};
  assign yE   = {1'b0, yCur};
  assign wE   = {1'b0, objW};
  assign hE   = {1'b0, objH};
  assign xMax = SCR_W - wE;
  assign yMax = SCR_H - hE;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    xNext  = xCur;
    yNext  = yCur;
    passUp = 1'b0;
    case (dir)
      2'(DIR_U): begin
        if (yE >= STP) begin
          yNext = COORD_W'(yE - STP);
        end else begin
          // Up always re-enters at the bottom and counts as a level pass
          yNext  = COORD_W'(yMax);
          passUp = 1'b1;
        end
      end
      2'(DIR_D): begin
        if (yE + hE + STP <= SCR_H) yNext = COORD_W'(yE + STP);
        else yNext = (EDGE_MODE == EDGE_CLAMP) ? COORD_W'(yMax) : '0;
      end
      2'(DIR_R): begin
        if (xE + wE + STP <= SCR_W) xNext = COORD_W'(xE + STP);
        else xNext = (EDGE_MODE == EDGE_CLAMP) ? COORD_W'(xMax) : '0;
      end
      default: begin
        if (xE >= STP) xNext = COORD_W'(xE - STP);
        else xNext = (EDGE_MODE == EDGE_CLAMP) ? '0 : COORD_W'(xMax);
      end
    endcase
  end

endmodule

// File: rtl/player_mover.sv
// -----------------------------------------------------------------------------
// player_mover
// Keeps a player object's position from a debounced 4-button input.
// A one-hot press edge moves the object one STEP; holding the button can
// auto-repeat every REPEAT_TICKS cycles. Up-moves off the top edge latch a
// sticky level_passed flag.
// Optional feature macro: PLAYER_MOVE_COUNT_EN adds move_count.
// Ports:
//   btnClk        in  1        clock
//   rst           in  1        asynchronous active-high reset
//   btns          in  4        buttons [3]=U [2]=D [1]=R [0]=L
//   move_en       in  4        per-direction enable (0 = blocked)
//   load          in  1        synchronous reload of start position
//   start_x/y     in  COORD_W  start position (top-left)
//   obj_w/h       in  COORD_W  object size
//   x, y          out COORD_W  current position, registered
//   moving        out 1        FSM is in HOLD
//   blocked       out 1        one-cycle pulse: move hit a disabled direction
//   level_passed  out 1        sticky level-pass flag
//   move_count    out 16       (PLAYER_MOVE_COUNT_EN) saturating executed-move count
// -----------------------------------------------------------------------------
module player_mover #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int COORD_W      = 11,
  parameter int STEP         = 12,
  parameter int EDGE_MODE    = 0,
  parameter int REPEAT_TICKS = 0
) (
  input  logic               btnClk,
  input  logic               rst,
  input  logic [3:0]         btns,
  input  logic [3:0]         move_en,
  input  logic               load,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [COORD_W-1:0] obj_w,
  input  logic [COORD_W-1:0] obj_h,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               moving,
  output logic               blocked,
`ifdef PLAYER_MOVE_COUNT_EN
  output logic [15:0]        move_count,
`endif
  output logic               level_passed
);
  import player_pkg::*;

  localparam int CNT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic [3:0]         btnsQ;
  moverState_t        state, stateNext;
  logic [CNT_W-1:0]   repCnt, repCntNext;
  logic               btnsValid, pressEdge, stillHeld, repeatFire, doMove;
  logic [1:0]         dir;
  logic [COORD_W-1:0] xNext, yNext;
  logic               passUp;

  assign btnsValid = $onehot(btns);
  assign pressEdge = btnsValid && (btns != btnsQ);
  // In HOLD, btnsQ always holds the pressed value, so "same one-hot" is btns == btnsQ
  assign stillHeld = btnsValid && (btns == btnsQ);
  assign dir       = dirIndex(btns);
  assign moving    = (state == HOLD);

  assign repeatFire = (REPEAT_TICKS > 0) && (state == HOLD) && stillHeld && (repCnt == REP_LAST);
  assign doMove     = ((state == IDLE) && pressEdge) || repeatFire;

  player_step_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .COORD_W  (COORD_W),
    .STEP     (STEP),
    .EDGE_MODE(EDGE_MODE)
  ) stepCalc (
    .dir   (dir),
    .xCur  (x),
    .yCur  (y),
    .objW  (obj_w),
    .objH  (obj_h),
    .xNext (xNext),
    .yNext (yNext),
    .passUp(passUp)
  );

  always_comb begin
    stateNext  = state;
    repCntNext = '0;
    case (state)
      IDLE: if (pressEdge) stateNext = HOLD;
      default: begin
        if (!stillHeld) begin
          stateNext = IDLE;
        end else if (REPEAT_TICKS > 0) begin
          repCntNext = repeatFire ? '0 : repCnt + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // The async reset loads start_x/start_y, which are quasi-static configuration inputs.
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      x            <= start_x;
      y            <= start_y;
      level_passed <= 1'b0;
      blocked      <= 1'b0;
      state        <= IDLE;
      repCnt       <= '0;
      btnsQ        <= '0;
    end else begin
      btnsQ   <= btns;
      blocked <= 1'b0;
      if (load) begin
        x            <= start_x;
        y            <= start_y;
        level_passed <= 1'b0;
        state        <= IDLE;
        repCnt       <= '0;
      end else begin
        state  <= stateNext;
        repCnt <= repCntNext;
        if (doMove) begin
          if (move_en[dir]) begin
            x <= xNext;
            y <= yNext;
            if (passUp) level_passed <= 1'b1;
          end else begin
            blocked <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PLAYER_MOVE_COUNT_EN
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      move_count <= '0;
    end else if (load) begin
      move_count <= '0;
    end else if (doMove && move_en[dir] && (move_count != 16'hFFFF)) begin
      move_count <= move_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_player_mover.sv
// -----------------------------------------------------------------------------
// tb_player_mover
// Self-checking bench for player_mover. Three instances share the stimulus:
//   dut0 defaults (wrap, no repeat), dutC clamp edges, dutR REPEAT_TICKS=4.
// Single-press vectors are table-driven; wrap/clamp, level pass, load,
// auto-repeat and reset-mid-HOLD are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_player_mover;

  localparam int CW = 11;

  logic          btnClk = 1'b0;
  logic          rst;
  logic [3:0]    btns;
  logic [3:0]    move_en;
  logic          load;
  logic [CW-1:0] start_x, start_y, obj_w, obj_h;

  logic [CW-1:0] x0, y0, xC, yC, xR, yR;
  logic          mov0, movC, movR, blk0, blkC, blkR, lvl0, lvlC, lvlR;
`ifdef PLAYER_MOVE_COUNT_EN
  logic [15:0]   mc0, mcC, mcR;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 btnClk = ~btnClk;

  player_mover dut0 (
    .btnClk(btnClk), .rst(rst), .btns(btns), .move_en(move_en), .load(load),
    .start_x(start_x), .start_y(start_y), .obj_w(obj_w), .obj_h(obj_h),
    .x(x0), .y(y0), .moving(mov0), .blocked(blk0),
`ifdef PLAYER_MOVE_COUNT_EN
    .move_count(mc0),
`endif
    .level_passed(lvl0)
  );

  player_mover #(.EDGE_MODE(1)) dutC (
    .btnClk(btnClk), .rst(rst), .btns(btns), .move_en(move_en), .load(load),
    .start_x(start_x), .start_y(start_y), .obj_w(obj_w), .obj_h(obj_h),
    .x(xC), .y(yC), .moving(movC), .blocked(blkC),
`ifdef PLAYER_MOVE_COUNT_EN
    .move_count(mcC),
`endif
    .level_passed(lvlC)
  );

  player_mover #(.REPEAT_TICKS(4)) dutR (
    .btnClk(btnClk), .rst(rst), .btns(btns), .move_en(move_en), .load(load),
    .start_x(start_x), .start_y(start_y), .obj_w(obj_w), .obj_h(obj_h),
    .x(xR), .y(yR), .moving(movR), .blocked(blkR),
`ifdef PLAYER_MOVE_COUNT_EN
    .move_count(mcR),
`endif
    .level_passed(lvlR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge btnClk);
    #1;
  endtask

  task automatic doLoad(input logic [CW-1:0] sx, input logic [CW-1:0] sy);
    @(negedge btnClk);
    start_x = sx;
    start_y = sy;
    load    = 1'b1;
    tick();
    @(negedge btnClk);
    load = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge btnClk);
    btns = b;
    tick();
  endtask

  task automatic release_btns();
    @(negedge btnClk);
    btns = 4'b0000;
    tick();
  endtask

  typedef struct {
    logic [3:0]    b;
    logic [3:0]    en;
    logic [CW-1:0] expX;
    logic [CW-1:0] expY;
    logic          expBlk;
    logic          expMov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Single presses from (100,200), obj 20x20, defaults
    vecs[0] = '{4'b0010, 4'b1111, 11'd112, 11'd200, 1'b0, 1'b1};
    vecs[1] = '{4'b0100, 4'b1111, 11'd112, 11'd212, 1'b0, 1'b1};
    vecs[2] = '{4'b0001, 4'b1111, 11'd100, 11'd212, 1'b0, 1'b1};
    vecs[3] = '{4'b1000, 4'b1111, 11'd100, 11'd200, 1'b0, 1'b1};
    vecs[4] = '{4'b1000, 4'b0111, 11'd100, 11'd200, 1'b1, 1'b1};
    vecs[5] = '{4'b1100, 4'b1111, 11'd100, 11'd200, 1'b0, 1'b0};
    vecs[6] = '{4'b0000, 4'b1111, 11'd100, 11'd200, 1'b0, 1'b0};
    vecs[7] = '{4'b0010, 4'b1101, 11'd100, 11'd200, 1'b1, 1'b1};

    rst = 1'b1; btns = 4'b0000; move_en = 4'b1111; load = 1'b0;
    start_x = 11'd100; start_y = 11'd200; obj_w = 11'd20; obj_h = 11'd20;
    #12;
    check("reset_x", 32'(x0), 100);
    check("reset_y", 32'(y0), 200);
    check("reset_moving", 32'(mov0), 0);
    check("reset_blocked", 32'(blk0), 0);
    check("reset_level", 32'(lvl0), 0);
    @(negedge btnClk);
    rst = 1'b0;

    // Table-driven single presses
    for (int i = 0; i < 8; i++) begin
      @(negedge btnClk);
      move_en = vecs[i].en;
      btns    = vecs[i].b;
      tick();
      check($sformatf("vec%0d_x", i), 32'(x0), 32'(vecs[i].expX));
      check($sformatf("vec%0d_y", i), 32'(y0), 32'(vecs[i].expY));
      check($sformatf("vec%0d_blocked", i), 32'(blk0), 32'(vecs[i].expBlk));
      check($sformatf("vec%0d_moving", i), 32'(mov0), 32'(vecs[i].expMov));
      release_btns();
      check($sformatf("vec%0d_blocked_clear", i), 32'(blk0), 0);
      check($sformatf("vec%0d_moving_clear", i), 32'(mov0), 0);
    end
    move_en = 4'b1111;

    // Right edge: wrap vs clamp, then left from there
    doLoad(11'd615, 11'd200);
    press(4'b0010);
    check("r_wrap_x", 32'(x0), 0);
    check("r_clamp_x", 32'(xC), 620);
    release_btns();
    press(4'b0001);
    check("l_wrap_x", 32'(x0), 620);
    check("l_clamp_x", 32'(xC), 608);
    release_btns();

    // Bottom edge
    doLoad(11'd100, 11'd460);
    press(4'b0100);
    check("d_wrap_y", 32'(y0), 0);
    check("d_clamp_y", 32'(yC), 460);
    release_btns();

    // Level pass, sticky, cleared by load
    doLoad(11'd100, 11'd5);
    press(4'b1000);
    check("u_pass_y", 32'(y0), 460);
    check("u_pass_level", 32'(lvl0), 1);
    check("u_pass_clamp_y", 32'(yC), 460);
    release_btns();
    press(4'b1000);
    check("u_after_y", 32'(y0), 448);
    check("u_level_sticky", 32'(lvl0), 1);
    release_btns();
    doLoad(11'd100, 11'd5);
    check("load_y", 32'(y0), 5);
    check("load_level", 32'(lvl0), 0);

    // Press edge coinciding with load is dropped; held button makes no later edge
    @(negedge btnClk);
    start_x = 11'd100; start_y = 11'd200; load = 1'b1; btns = 4'b0010;
    tick();
    @(negedge btnClk);
    load = 1'b0;
    tick();
    check("load_press_x", 32'(x0), 100);
    check("load_press_moving", 32'(mov0), 0);
    release_btns();

    // Auto-repeat: hold L for 13 cycles
    doLoad(11'd100, 11'd200);
    press(4'b0001);
    check("rep_first_x", 32'(xR), 88);
    for (int c = 1; c < 13; c++) tick();
    check("rep_x", 32'(xR), 52);
    check("rep_moving", 32'(movR), 1);
    check("norep_x", 32'(x0), 88);
    check("norep_moving", 32'(mov0), 1);
    release_btns();
    check("rep_release_moving", 32'(movR), 0);
    check("rep_release_x", 32'(xR), 52);

    // Reset in the middle of HOLD, button held through reset release
    doLoad(11'd100, 11'd200);
    press(4'b0010);
    check("prerst_x", 32'(x0), 112);
    check("prerst_moving", 32'(mov0), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_x", 32'(x0), 100);
    check("async_rst_moving", 32'(mov0), 0);
    @(posedge btnClk);
    @(negedge btnClk);
    rst = 1'b0;
    tick();
    check("post_rst_x", 32'(x0), 112);
    check("post_rst_moving", 32'(mov0), 1);
    release_btns();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
